// File: rtl/user_str_fetch_pkg.sv
// Shared types for the OBI string fetcher: FSM state encoding and the OBI
// request/response structs used on the manager port.
package user_str_fetch_pkg;

  localparam int unsigned BytesPerWord  = 4;
  localparam int unsigned ObiAddrWidth  = 32;
  localparam int unsigned ObiDataWidth  = 32;
  localparam int unsigned ObiIdWidth    = 1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    DONE
  } str_fetch_state_e;

  typedef struct packed {
    logic [ObiAddrWidth-1:0]   addr;
    logic                      we;
    logic [BytesPerWord-1:0]   be;
    logic [ObiDataWidth-1:0]   wdata;
    logic [ObiIdWidth-1:0]     aid;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } obi_req_t;

  typedef struct packed {
    logic [ObiDataWidth-1:0] rdata;
    logic [ObiIdWidth-1:0]   rid;
    logic                    err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

endpackage

// File: rtl/user_str_fetch.sv
// OBI manager that fetches a NUL-terminated string word by word and streams it
// out as bytes. Optional macro USER_STR_FETCH_RID_CHECK_EN aborts on rid != ReqId.
module user_str_fetch
  import user_str_fetch_pkg::*;
#(
  parameter int unsigned           MaxWords = 8,
  parameter logic [ObiIdWidth-1:0] ReqId    = '0,
  localparam int unsigned          LenWidth = $clog2(MaxWords * BytesPerWord) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [ObiAddrWidth-1:0] base_addr_i,
  output obi_req_t                obi_req_o,
  input  obi_rsp_t                obi_rsp_i,
  output logic [7:0]              char_o,
  output logic                    char_valid_o,
  input  logic                    char_ready_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [LenWidth-1:0]     len_o
);

  localparam int unsigned WcntWidth = $clog2(MaxWords + 1);

  str_fetch_state_e         state_q;
  obi_req_t                 req_q;
  logic [ObiDataWidth-1:0]  word_buf_q;
  logic [1:0]               byte_idx_q;
  logic [WcntWidth-1:0]     word_cnt_q;
  logic [7:0]               char_q;
  logic                     valid_q;
  logic                     done_q;
  logic                     err_q;
  logic [LenWidth-1:0]      len_q;

  logic [1:0] next_idx;
  logic [7:0] next_byte;
  logic       rsp_ok;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    next_idx  = byte_idx_q + 2'd1;
    next_byte = '0;
    case (next_idx)
      2'd0: next_byte = word_buf_q[7:0];
      2'd1: next_byte = word_buf_q[15:8];
      2'd2: next_byte = word_buf_q[23:16];
      2'd3: next_byte = word_buf_q[31:24];
      default: next_byte = '0;
    endcase
  end

`ifdef USER_STR_FETCH_RID_CHECK_EN
  assign rsp_ok = !obi_rsp_i.r.err && (obi_rsp_i.r.rid == ReqId);
`else
  assign rsp_ok = !obi_rsp_i.r.err;
  logic unused_rid;
  assign unused_rid = ^obi_rsp_i.r.rid;
`endif

  // NOTE: sequential state uses non-blocking assignments only; the async reset
  // also clears the word buffer so char_o never exposes stale data after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      req_q      <= '0;
      word_buf_q <= '0;
      byte_idx_q <= '0;
      word_cnt_q <= '0;
      char_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      len_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q       <= REQ;
            req_q.req     <= 1'b1;
            req_q.a.addr  <= {base_addr_i[ObiAddrWidth-1:2], 2'b00};
            req_q.a.we    <= 1'b0;
            req_q.a.be    <= '1;
            req_q.a.wdata <= '0;
            req_q.a.aid   <= ReqId;
            len_q         <= '0;
            err_q         <= 1'b0;
            word_cnt_q    <= '0;
          end
        end
        REQ: begin
          if (obi_rsp_i.gnt) begin
            req_q.req <= 1'b0;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (obi_rsp_i.rvalid) begin
            if (rsp_ok) begin
              word_buf_q <= obi_rsp_i.r.rdata;
              byte_idx_q <= '0;
              char_q     <= obi_rsp_i.r.rdata[7:0];
              valid_q    <= (obi_rsp_i.r.rdata[7:0] != 8'h00);
              word_cnt_q <= word_cnt_q + WcntWidth'(1);
              state_q    <= DRAIN;
            end else begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DRAIN: begin
          if (!valid_q) begin
            // The current byte is the terminator: finish without emitting it.
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (char_ready_i) begin
            len_q <= len_q + LenWidth'(1);
            if (byte_idx_q == 2'd3) begin
              valid_q <= 1'b0;
              if (word_cnt_q == WcntWidth'(MaxWords)) begin
                done_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                req_q.req    <= 1'b1;
                req_q.a.addr <= req_q.a.addr + ObiAddrWidth'(BytesPerWord);
                state_q      <= REQ;
              end
            end else begin
              byte_idx_q <= next_idx;
              char_q     <= next_byte;
              valid_q    <= (next_byte != 8'h00);
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign obi_req_o    = req_q;
  assign char_o       = char_q;
  assign char_valid_o = valid_q;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign len_o        = len_q;

endmodule

// File: doc/user_str_fetch.md
# user_str_fetch

OBI manager that fetches a NUL-terminated ASCII string from an OBI subordinate. It starts at a given base address, reads one 32-bit word at a time and unpacks each word little-endian. The result is a byte stream with a valid/ready handshake. It sits in the user domain as the initiator counterpart to user-domain read-only subordinates, for example as a boot-banner source for a UART or a display.

## Interface
- ObiCfg, default obi_pkg::ObiDefaultConfig: OBI configuration for the manager port.
- obi_req_t, default logic: OBI request struct.
- obi_rsp_t, default logic: OBI response struct.
- MaxWords, default 8: maximum number of words fetched per string (8 words = 32 chars).
- ReqId, default 0: constant aid driven on every request.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  start pulse; ignored while busy_o=1.
- base_addr_i  in  ObiCfg.AddrWidth  string start address; bits [1:0] are forced to 0.
- obi_req_o  out  obi_req_t  OBI A channel request.
- obi_rsp_i  in  obi_rsp_t  OBI grant and R channel response.
- char_o  out  8  current character.
- char_valid_o  out  1  char_o is valid.
- char_ready_i  in  1  consumer accepts char_o.
- busy_o  out  1  a fetch is in progress (state is not IDLE).
- done_o  out  1  one-cycle pulse on completion or abort.
- err_o  out  1  sticky error; cleared on an accepted start_i.
- len_o  out  $clog2(MaxWords*4)+1  characters emitted; held until the next accepted start.

## Operation
- FSM states: IDLE, REQ, WAIT, DRAIN, DONE.
- IDLE → REQ on start_i:
  - Latch the word-aligned base address.
  - Clear len_o, err_o and the word counter.
- REQ:
  - Drive req=1, we=0, be=4'hF, wdata=0, aid=ReqId, addr=current address.
  - All A-channel fields are held stable until gnt.
  - On gnt → WAIT.
- WAIT:
  - req=0. On rvalid with err=0: capture rdata into the word buffer, set byte index to 0, → DRAIN.
  - On rvalid with err=1: set err_o → DONE; no bytes from that word are emitted.
- DRAIN:
  - char_o is buffer byte[index], taking byte 0 = rdata[7:0] first.
  - If the byte is 0x00: no valid is raised, → DONE. The NUL itself is never emitted.
  - Otherwise assert char_valid_o; on char_ready_i, increment len_o and the index.
  - After byte 3 is accepted: if the word count reaches MaxWords → DONE; else address += 4 (wraps modulo 2^AddrWidth) → REQ.
- DONE: done_o=1 for one cycle, → IDLE.
- At most one outstanding transaction at any time.
- rvalid outside WAIT is ignored.
- A start_i held high across DONE does not retrigger until IDLE is reached.
- Reset mid-operation: return to IDLE immediately. Any in-flight response is not awaited.
- Reset values: obi_req_o all-zero, char_o=0, char_valid_o=0, busy_o=0, done_o=0, err_o=0, len_o=0.

## Timing
- All outputs are decoded from registered state and buffers only. There is no combinational path from obi_rsp_i or char_ready_i to obi_req_o.
- With a subordinate granting in the same cycle and responding one cycle later, and char_ready_i=1:
  - start_i at cycle 0: req=1 in cycle 1, rvalid in cycle 2, first char_valid_o in cycle 3.
  - Each full word costs 6 cycles.
- char_valid_o stays high with char_o stable until char_ready_i; it never drops without a handshake.
- Backpressure stalls only DRAIN. No new request is issued while bytes are pending.

## Configuration
- USER_STR_FETCH_RID_CHECK_EN defined:
  - In WAIT, a response with rid ≠ ReqId is treated as an error: err_o=1, → DONE.
- USER_STR_FETCH_RID_CHECK_EN undefined:
  - rid is ignored; only r.err can abort.

## Structure
- Shared package user_str_fetch_pkg holds:
  - typedef enum logic [2:0] str_fetch_state_e {IDLE, REQ, WAIT, DRAIN, DONE}
  - localparam BytesPerWord = 4
- No sub-module is needed. Byte selection is a 4:1 mux on the index inside user_str_fetch.

## Test plan
- Subordinate holds 32'h00216948 ("Hi!\0") at 0x100; start with base 0x100 and ready=1 → chars 0x48, 0x69, 0x21, len_o=3, err_o=0, one done_o pulse, exactly one OBI request.
- 8 words with no NUL, MaxWords=8 → 32 chars emitted, addresses 0x0..0x1C in order, len_o=32, done_o pulses after the last char.
- char_ready_i toggling 1-of-3 cycles → char_o stable while valid, no chars lost or duplicated, no request while bytes are pending.
- Subordinate grants 3 cycles late and returns err=1 on the second word → A fields stable while waiting; first-word chars emitted, err_o=1, done_o pulses, len_o=4.
- rst_ni asserted while in WAIT → all outputs return to reset values the same cycle; a following start fetches normally.
- With the macro defined, response rid=1 while ReqId=0 → err_o=1, no chars emitted; with the macro undefined, the word is emitted normally.
